// File: rtl/dpram_port_master.sv
// Single-clock FIFO: data is visible the cycle after push, and out_dat holds while stalled.
// Pointers carry one wrap bit, so full and empty are told apart without a counter.
module fifo_sync #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_dat,
   output logic             full
);
   localparam int PW = $clog2(DEPTH);

   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push;
   logic             pop;

   assign out_vld = (wr_ptr != rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign push    = in_vld && !full;
   assign pop     = out_vld && out_rdy;
   assign out_dat = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PW-1:0]] <= in_dat;
   end
endmodule

// Drives one RAM port from a valid/ready command stream and returns read data in order.
// Read latency 2 cycles; CMD_READY drops while OUTSTANDING reaches RSP_DEPTH.
module dpram_port_master #(
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 5,
   parameter int RSP_DEPTH = 4,
   parameter int CWIDTH    = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WE,
   input  logic [AWIDTH-1:0] CMD_ADDR,
   input  logic [DWIDTH-1:0] CMD_WDATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DWIDTH-1:0] RSP_RDATA,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [AWIDTH-1:0] MEM_ADDR,
   output logic [DWIDTH-1:0] MEM_DIN,
   input  logic [DWIDTH-1:0] MEM_DOUT,
   output logic [CWIDTH-1:0] OUTSTANDING
);
   logic rd_acc;
   logic rsp_pop;
   logic rd_pending;
   logic fifo_full;

   // Credit counts reads still in the RAM pipe as well as FIFO entries, so a
   // full FIFO can never be pushed.
   assign CMD_READY = !RST && (OUTSTANDING < CWIDTH'(RSP_DEPTH));
   assign MEM_EN    = CMD_VALID && CMD_READY;
   assign MEM_WE    = CMD_WE;
   assign MEM_ADDR  = CMD_ADDR;
   assign MEM_DIN   = CMD_WDATA;

   assign rd_acc  = MEM_EN && !CMD_WE;
   assign rsp_pop = RSP_VALID && RSP_READY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_pending  <= 1'b0;
         OUTSTANDING <= '0;
      end else begin
         rd_pending  <= rd_acc;
         OUTSTANDING <= OUTSTANDING + CWIDTH'(rd_acc) - CWIDTH'(rsp_pop);
      end
   end

   // DOUT is held by the RAM on write cycles, so rd_pending alone qualifies capture.
   fifo_sync #(
      .WIDTH (DWIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (CLK),
      .rst     (RST),
      .in_vld  (rd_pending),
      .in_dat  (MEM_DOUT),
      .out_vld (RSP_VALID),
      .out_rdy (RSP_READY),
      .out_dat (RSP_RDATA),
      .full    (fifo_full)
   );

   a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(rd_pending && fifo_full));
   a_credit_bound: assert property (@(posedge CLK) disable iff (RST) OUTSTANDING <= CWIDTH'(RSP_DEPTH));
endmodule

// File: tb/tb_dpram_port_master.sv
// Bench for dpram_port_master: a behavioural RAM on the port, plus a reference
// model of RAM contents and a queue of expected read data with handshake times.
module tb_dpram_port_master;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 4;
   localparam int CW = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          CMD_VALID;
   logic          CMD_READY;
   logic          CMD_WE;
   logic [AW-1:0] CMD_ADDR;
   logic [DW-1:0] CMD_WDATA;
   logic          RSP_VALID;
   logic          RSP_READY;
   logic [DW-1:0] RSP_RDATA;
   logic          MEM_EN;
   logic          MEM_WE;
   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_DIN;
   logic [DW-1:0] MEM_DOUT = '0;
   logic [CW-1:0] OUTSTANDING;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [DW-1:0] ram [32] = '{default: '0};
   logic [DW-1:0] ref_mem [32] = '{default: '0};
   logic [DW-1:0] exp_q [$];
   int            t_q [$];
   int            exp_out;
   bit            exp_rdy;

   dpram_port_master #(
      .DWIDTH(DW), .AWIDTH(AW), .RSP_DEPTH(DEPTH), .CWIDTH(CW)
   ) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WE(CMD_WE),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
      .MEM_DOUT(MEM_DOUT), .OUTSTANDING(OUTSTANDING)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // RAM port: 1-cycle registered read, DOUT held on write cycles.
   always @(posedge CLK) begin
      if (MEM_EN) begin
         if (MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
         else        MEM_DOUT <= ram[MEM_ADDR];
      end
   end

   task automatic drive(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit rr);
      CMD_VALID = v;
      CMD_WE    = we;
      CMD_ADDR  = a;
      CMD_WDATA = d;
      RSP_READY = rr;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Mid-cycle: record model expectations, then apply this cycle's handshakes to the model.
   task automatic sample(output bit hs, output bit pop, output logic [DW-1:0] exp_rd, output int lat);
      @(negedge CLK);
      exp_out = exp_q.size();
      exp_rdy = !RST && (exp_out < DEPTH);
      pop = RSP_VALID && RSP_READY;
      exp_rd = 'x;
      lat = -1;
      if (pop && exp_q.size() != 0) begin
         exp_rd = exp_q.pop_front();
         lat = cyc - t_q.pop_front();
      end
      hs = CMD_VALID && CMD_READY;
      if (hs && CMD_WE) ref_mem[CMD_ADDR] = CMD_WDATA;
      else if (hs) begin
         exp_q.push_back(ref_mem[CMD_ADDR]);
         t_q.push_back(cyc);
      end
      if (RST) begin
         exp_q.delete();
         t_q.delete();
      end
   endtask

   task automatic test_reset();
      bit hs, pop;
      logic [DW-1:0] e;
      int lat;
      RST = 1'b1;
      drive(1, 0, 5'd1, '0, 0);
      step();
      repeat (3) begin
         sample(hs, pop, e, lat);
         n_checks++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", MEM_EN); end
         n_checks++; if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", CMD_READY); end
         n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
         n_checks++; if (OUTSTANDING !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", OUTSTANDING); end
         step();
      end
      RST = 1'b0;
      drive(0, 0, '0, '0, 1);
   endtask

   task automatic test_write_read();
      bit hs, pop;
      logic [DW-1:0] e;
      int lat;
      drive(1, 1, 5'd5, 32'hDEADBEEF, 1);
      sample(hs, pop, e, lat);
      n_checks++; if ({MEM_EN, MEM_WE} !== 2'b11) begin n_fail++; $display("FAIL wr_strobes: got %b want 11", {MEM_EN, MEM_WE}); end
      step();
      drive(1, 0, 5'd5, '0, 1);
      sample(hs, pop, e, lat);
      n_checks++; if ({MEM_EN, MEM_WE} !== 2'b10) begin n_fail++; $display("FAIL rd_strobes: got %b want 10", {MEM_EN, MEM_WE}); end
      step();
      drive(0, 0, '0, '0, 1);
      for (int k = 1; k <= 3; k++) begin
         sample(hs, pop, e, lat);
         if (k == 2) begin
            n_checks++; if (RSP_VALID !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid_lat2: got %b want 1", RSP_VALID); end
            n_checks++; if (RSP_RDATA !== e) begin n_fail++; $display("FAIL wr_rd_data: got %h want %h", RSP_RDATA, e); end
            n_checks++; if (lat != 2) begin n_fail++; $display("FAIL wr_rd_latency: got %0d want 2", lat); end
         end else begin
            n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL wr_rd_valid_k%0d: got %b want 0", k, RSP_VALID); end
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      bit hs, pop;
      logic [DW-1:0] e;
      int lat, pops, last;
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, AW'(i), DW'(32'h100 + i), 1);
         sample(hs, pop, e, lat);
         n_checks++; if (hs !== 1'b1) begin n_fail++; $display("FAIL fill_accept[%0d]: got %b want 1", i, hs); end
         step();
      end
      pops = 0;
      last = 0;
      for (int c = 0; c < 20 && pops < 8; c++) begin
         drive(c < 8, 0, AW'(c), '0, 1);
         sample(hs, pop, e, lat);
         if (c < 8) begin
            n_checks++; if (hs !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d]: got %b want 1", c, hs); end
         end
         if (pop) begin
            n_checks++; if (RSP_RDATA !== DW'(32'h100 + pops)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", pops, RSP_RDATA, 32'h100 + pops); end
            if (pops > 0) begin
               n_checks++; if (cyc != last + 1) begin n_fail++; $display("FAIL b2b_contiguous[%0d]: got gap %0d want 1", pops, cyc - last); end
            end
            last = cyc;
            pops++;
         end
         step();
      end
      n_checks++; if (pops != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", pops); end
   endtask

   task automatic test_backpressure();
      bit hs, pop, have_hold;
      logic [DW-1:0] e, hold;
      int lat, req, pops, first_pop, last;
      req = 0;
      pops = 0;
      have_hold = 0;
      hold = '0;
      for (int c = 0; c < 8; c++) begin
         drive(req < 6, 0, AW'(req), '0, 0);
         sample(hs, pop, e, lat);
         if (hs) req++;
         if (RSP_VALID) begin
            if (have_hold) begin
               n_checks++; if (RSP_RDATA !== hold) begin n_fail++; $display("FAIL bp_rdata_stable: got %h want %h", RSP_RDATA, hold); end
            end
            hold = RSP_RDATA;
            have_hold = 1;
         end
         step();
      end
      n_checks++; if (req != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", req); end
      n_checks++; if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready: got %b want 0", CMD_READY); end
      n_checks++; if (OUTSTANDING !== CW'(4)) begin n_fail++; $display("FAIL bp_outstanding: got %0d want 4", OUTSTANDING); end
      first_pop = -1;
      last = 0;
      for (int c = 0; c < 30 && pops < 6; c++) begin
         drive(req < 6, 0, AW'(req), '0, 1);
         sample(hs, pop, e, lat);
         if (first_pop >= 0 && cyc == first_pop + 1) begin
            n_checks++; if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reassert: got %b want 1", CMD_READY); end
         end
         if (pop) begin
            if (first_pop < 0) begin
               first_pop = cyc;
               n_checks++; if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready_at_pop: got %b want 0", CMD_READY); end
            end
            n_checks++; if (RSP_RDATA !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", pops, RSP_RDATA, e); end
            if (pops > 0) begin
               n_checks++; if (cyc != last + 1) begin n_fail++; $display("FAIL bp_contiguous[%0d]: got gap %0d want 1", pops, cyc - last); end
            end
            last = cyc;
            pops++;
         end
         if (hs) req++;
         step();
      end
      n_checks++; if (pops != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", pops); end
   endtask

   task automatic test_mixed();
      bit hs, pop;
      logic [DW-1:0] e;
      int lat, pops;
      pops = 0;
      for (int c = 0; c < 10; c++) begin
         drive(c < 3, c == 1, 5'd3, 32'h55, 1);
         sample(hs, pop, e, lat);
         if (c < 3) begin
            n_checks++; if (hs !== 1'b1) begin n_fail++; $display("FAIL mixed_accept[%0d]: got %b want 1", c, hs); end
         end
         if (pop) begin
            n_checks++; if (RSP_RDATA !== e) begin n_fail++; $display("FAIL mixed_data[%0d]: got %h want %h", pops, RSP_RDATA, e); end
            pops++;
         end
         step();
      end
      n_checks++; if (pops != 2) begin n_fail++; $display("FAIL mixed_rsp_count: got %0d want 2", pops); end
   endtask

   task automatic test_reset_mid();
      bit hs, pop;
      logic [DW-1:0] e;
      int lat;
      drive(1, 0, 5'd4, '0, 1);
      sample(hs, pop, e, lat);
      n_checks++; if (hs !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept: got %b want 1", hs); end
      step();
      RST = 1'b1;
      drive(0, 0, '0, '0, 1);
      repeat (2) begin
         sample(hs, pop, e, lat);
         step();
      end
      RST = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sample(hs, pop, e, lat);
         n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rsp[%0d]: got %b want 0", k, RSP_VALID); end
         n_checks++; if (OUTSTANDING !== '0) begin n_fail++; $display("FAIL rstmid_outstanding[%0d]: got %0d want 0", k, OUTSTANDING); end
         step();
      end
      drive(1, 0, 5'd4, '0, 1);
      sample(hs, pop, e, lat);
      step();
      drive(0, 0, '0, '0, 1);
      for (int k = 1; k <= 2; k++) begin
         sample(hs, pop, e, lat);
         if (k == 2) begin
            n_checks++; if (RSP_VALID !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_valid: got %b want 1", RSP_VALID); end
            n_checks++; if (RSP_RDATA !== e) begin n_fail++; $display("FAIL rstmid_fresh_data: got %h want %h", RSP_RDATA, e); end
         end else begin
            n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_fresh_early: got %b want 0", RSP_VALID); end
         end
         step();
      end
   endtask

   task automatic test_random();
      bit hs, pop, stall_prev;
      logic [DW-1:0] e, prev;
      int lat;
      stall_prev = 0;
      prev = '0;
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)),
               DW'($urandom), $urandom_range(0, 3) != 0);
         sample(hs, pop, e, lat);
         n_checks++; if (CMD_READY !== exp_rdy) begin n_fail++; $display("FAIL rnd_cmd_ready@%0d: got %b want %b", c, CMD_READY, exp_rdy); end
         n_checks++; if (MEM_EN !== (CMD_VALID && exp_rdy)) begin n_fail++; $display("FAIL rnd_mem_en@%0d: got %b want %b", c, MEM_EN, CMD_VALID && exp_rdy); end
         n_checks++; if (OUTSTANDING !== CW'(exp_out)) begin n_fail++; $display("FAIL rnd_outstanding@%0d: got %0d want %0d", c, OUTSTANDING, exp_out); end
         n_checks++; if ({MEM_WE, MEM_ADDR, MEM_DIN} !== {CMD_WE, CMD_ADDR, CMD_WDATA}) begin n_fail++; $display("FAIL rnd_passthru@%0d: got %b/%h/%h want %b/%h/%h", c, MEM_WE, MEM_ADDR, MEM_DIN, CMD_WE, CMD_ADDR, CMD_WDATA); end
         if (pop) begin
            n_checks++; if (RSP_RDATA !== e) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", c, RSP_RDATA, e); end
            n_checks++; if (lat < 2) begin n_fail++; $display("FAIL rnd_latency@%0d: got %0d want >=2", c, lat); end
         end
         if (stall_prev) begin
            n_checks++; if ({RSP_VALID, RSP_RDATA} !== {1'b1, prev}) begin n_fail++; $display("FAIL rnd_stall_hold@%0d: got %b/%h want 1/%h", c, RSP_VALID, RSP_RDATA, prev); end
         end
         stall_prev = RSP_VALID && !RSP_READY;
         prev = RSP_RDATA;
         step();
      end
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         drive(0, 0, '0, '0, 1);
         sample(hs, pop, e, lat);
         if (pop) begin
            n_checks++; if (RSP_RDATA !== e) begin n_fail++; $display("FAIL rnd_drain_data: got %h want %h", RSP_RDATA, e); end
         end
         step();
      end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain_left: got %0d want 0", exp_q.size()); end
      n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL rnd_drain_valid: got %b want 0", RSP_VALID); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_mixed();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by time %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/dpram_port_master.md
Name: dpram_port_master

Overview:
- Request-side controller for one port of the team's dual-port RAM (ENx/WEx/ADDRx/DINx/DOUTx port, 1-cycle registered read, no read on write cycles).
- Converts a valid/ready command stream into RAM port strobes.
- Captures read data after the fixed RAM latency and returns it in order through a response FIFO with backpressure.
- Instantiated once per RAM port that a client engine drives.

Parameters:
DWIDTH, 32, data width; must match the RAM.
AWIDTH, 5, address width; must match the RAM.
RSP_DEPTH, 4, response FIFO entries (power of two, >= 2).
CWIDTH, 3, width of OUTSTANDING; must satisfy 2^CWIDTH > RSP_DEPTH.

Ports:
CLK  input  1  single clock; RAM port clock tied to the same net.
RST  input  1  synchronous, active-high reset.
CMD_VALID  input  1  command present.
CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY.
CMD_WE  input  1  1 = write, 0 = read.
CMD_ADDR  input  AWIDTH  word address.
CMD_WDATA  input  DWIDTH  write data.
RSP_VALID  output  1  read data available.
RSP_READY  input  1  consumer takes RSP_RDATA.
RSP_RDATA  output  DWIDTH  read data, in command order.
MEM_EN  output  1  to RAM ENx.
MEM_WE  output  1  to RAM WEx.
MEM_ADDR  output  AWIDTH  to RAM ADDRx.
MEM_DIN  output  DWIDTH  to RAM DINx.
MEM_DOUT  input  DWIDTH  from RAM DOUTx.
OUTSTANDING  output  CWIDTH  reads in flight plus FIFO occupancy.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RST).

Reset values:
- CMD_READY=0 while RST=1.
- MEM_EN=0, RSP_VALID=0, OUTSTANDING=0.
- FIFO pointers cleared; rd_pending cleared.
- RSP_RDATA value is don't-care while RSP_VALID=0.

Command acceptance and RAM strobes:
- CMD_READY = !RST && (OUTSTANDING < RSP_DEPTH).
  - CMD_READY does not depend on CMD_WE or CMD_VALID.
  - A FIFO pop in the same cycle does not free credit until the next cycle.
- MEM_EN = CMD_VALID & CMD_READY (combinational).
- MEM_WE = CMD_WE, MEM_ADDR = CMD_ADDR, MEM_DIN = CMD_WDATA, all passed straight through.
- No MEM_EN pulse is ever issued without a handshake.
- A write completes in the RAM at the accepting edge. Writes generate no response and do not change OUTSTANDING.

Read pipeline (handshake in cycle 0):
- RAM registers the read at the end of cycle 0.
- rd_pending=1 during cycle 1; MEM_DOUT sampled into the FIFO at the end of cycle 1.
- RSP_VALID=1 from cycle 2 (minimum latency 2, no bypass).
- rd_pending is a single register. Back-to-back reads are allowed each cycle; rd_pending is re-set every cycle a read is accepted.

OUTSTANDING:
- next = OUTSTANDING + (read accepted) - (RSP_VALID & RSP_READY).
- Simultaneous accept and pop leaves it unchanged.
- Never exceeds RSP_DEPTH.

Response FIFO:
- Circular buffer, pointer width log2(RSP_DEPTH)+1; wraps modulo RSP_DEPTH.
- Overflow cannot occur because of credit gating; if overflow is detected, the simulation assertion fires.
- RSP_RDATA is held stable while RSP_VALID=1 and RSP_READY=0.
- Strict in-order return.

Mixed traffic:
- A write accepted the cycle after a read does not corrupt that read's capture. The RAM holds DOUT on write cycles; capture is gated only by rd_pending.
- A read-after-write to the same address in consecutive cycles returns the new data.

Throughput:
- RSP_DEPTH=4 with RSP_READY held high gives one read per cycle sustained.
- RSP_DEPTH=2 limits reads to 2 accepted per 3 cycles.

Reset mid-operation:
- An in-flight read is discarded (rd_pending cleared).
- The FIFO is flushed; no RSP_VALID appears for pre-reset commands.
- RAM contents are not reset.

Test Plan:
- Reset: hold RST 3 cycles with CMD_VALID=1 -> MEM_EN stays 0, CMD_READY=0, RSP_VALID=0, OUTSTANDING=0 throughout.
- Write 0xDEADBEEF to addr 5, then read addr 5 next cycle -> MEM_EN/MEM_WE=1/1 then 1/0; RSP_VALID rises exactly 2 cycles after the read handshake with RSP_RDATA=0xDEADBEEF.
- Fill addr 0..7 with values 0x100+i, then issue 8 back-to-back reads with RSP_READY=1 -> one accept per cycle; responses 0x100..0x107 in order, contiguous.
- RSP_READY=0 with 6 reads offered -> exactly 4 accepted, CMD_READY=0, OUTSTANDING=4, RSP_RDATA stable. Then RSP_READY=1 -> one pop per cycle, CMD_READY reasserts the cycle after the first pop, and all 6 responses arrive in order.
- Alternate read A=3 / write A=3 (0x55) / read A=3 over cycles 0-2 -> responses are the old value, then 0x55; write produces no response.
- Assert RST the cycle after a read handshake -> no RSP_VALID after reset release; a fresh read returns correct data with latency 2.
